// File: rtl/pong_pkg.sv
// Shared Pong types and default geometry, used by the ball engine and by render.
package pong_pkg;

  localparam int unsigned PONG_CORDW        = 10;
  localparam int unsigned PONG_H_RES        = 640;
  localparam int unsigned PONG_V_RES        = 480;
  localparam int unsigned PONG_BALL_SIZE    = 8;
  localparam int unsigned PONG_BALL_SPEED   = 2;
  localparam int unsigned PONG_PAD_W        = 8;
  localparam int unsigned PONG_PAD_H        = 48;
  localparam int unsigned PONG_PAD_X_L      = 16;
  localparam int unsigned PONG_PAD_X_R      = 616;
  localparam int unsigned PONG_AI_SPEED     = 2;
  localparam int unsigned PONG_SERVE_FRAMES = 60;
  localparam int unsigned SCORE_W           = 4;

  typedef enum logic [2:0] {
    IDLE,
    PADDLES,
    SERVE_WAIT,
    MOVE,
    BOUNCE
  } state_t;

  typedef enum logic {
    DIR_NEG = 1'b0,
    DIR_POS = 1'b1
  } dir_t;

  // Score increment that sticks at the maximum value.
  function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
    return (s == '1) ? s : s + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/pong_ai_paddle.sv
// Right-paddle tracker: steps the paddle toward the ball centre, clamped to the play area.
module pong_ai_paddle #(
  parameter int unsigned CORDW     = 10,
  parameter int unsigned V_RES     = 480,
  parameter int unsigned BALL_SIZE = 8,
  parameter int unsigned PAD_H     = 48,
  parameter int unsigned AI_SPEED  = 2
) (
  input  logic [CORDW-1:0] ball_y,
  input  logic [CORDW-1:0] pad_y,
  output logic [CORDW-1:0] pad_y_next_c
);

  localparam int unsigned W1 = CORDW + 1;

  logic [W1-1:0] ball_c;
  logic [W1-1:0] pad_c;
  logic [W1-1:0] pad_max;
  logic [W1-1:0] pad_dn;

  always_comb begin
    ball_c       = W1'(ball_y) + W1'(BALL_SIZE / 2);
    pad_c        = W1'(pad_y) + W1'(PAD_H / 2);
    pad_max      = W1'(V_RES - PAD_H);
    pad_dn       = W1'(pad_y) + W1'(AI_SPEED);
    pad_y_next_c = pad_y;
    // Differences below AI_SPEED hold the paddle still to avoid jitter.
    if ((ball_c > pad_c) && ((ball_c - pad_c) >= W1'(AI_SPEED))) begin
      pad_y_next_c = (pad_dn > pad_max) ? CORDW'(pad_max) : CORDW'(pad_dn);
    end else if ((pad_c > ball_c) && ((pad_c - ball_c) >= W1'(AI_SPEED))) begin
      pad_y_next_c = (W1'(pad_y) < W1'(AI_SPEED)) ? '0 : CORDW'(W1'(pad_y) - W1'(AI_SPEED));
    end
  end

endmodule

// File: rtl/pong_ball_engine.sv
// Per-frame Pong state engine: on each vsync falling edge updates paddles, ball and scores.
module pong_ball_engine
  import pong_pkg::*;
#(
  parameter int unsigned CORDW        = PONG_CORDW,
  parameter int unsigned H_RES        = PONG_H_RES,
  parameter int unsigned V_RES        = PONG_V_RES,
  parameter int unsigned BALL_SIZE    = PONG_BALL_SIZE,
  parameter int unsigned BALL_SPEED   = PONG_BALL_SPEED,
  parameter int unsigned PAD_W        = PONG_PAD_W,
  parameter int unsigned PAD_H        = PONG_PAD_H,
  parameter int unsigned PAD_X_L      = PONG_PAD_X_L,
  parameter int unsigned PAD_X_R      = PONG_PAD_X_R,
  parameter int unsigned AI_SPEED     = PONG_AI_SPEED,
  parameter int unsigned SERVE_FRAMES = PONG_SERVE_FRAMES
) (
  input  logic               i_clk,
  input  logic               n_btn_rst,
  input  logic               n_vsync,
  input  logic               i_pad_valid,
  input  logic [CORDW-1:0]   i_pad_y,
  output logic [CORDW-1:0]   o_ball_x,
  output logic [CORDW-1:0]   o_ball_y,
  output logic [CORDW-1:0]   o_pad_l_y,
  output logic [CORDW-1:0]   o_pad_r_y,
  output logic [SCORE_W-1:0] o_score_l,
  output logic [SCORE_W-1:0] o_score_r,
  output logic               o_update_done
);

  localparam int unsigned W1       = CORDW + 1;
  localparam int unsigned SW       = $clog2(SERVE_FRAMES + 1);
  localparam int unsigned BALL_X0  = (H_RES - BALL_SIZE) / 2;
  localparam int unsigned BALL_Y0  = (V_RES - BALL_SIZE) / 2;
  localparam int unsigned PAD_Y0   = (V_RES - PAD_H) / 2;
  localparam int unsigned PAD_MAX  = V_RES - PAD_H;
  localparam int unsigned BALL_XMX = H_RES - BALL_SIZE;
  localparam int unsigned BALL_YMX = V_RES - BALL_SIZE;

  state_t          state;
  logic            vsync_cur;
  logic            vsync_prev;
  logic            trigger;
  dir_t            dx;
  dir_t            dy;
  logic            miss_l;
  logic            miss_r;
  logic [CORDW-1:0] pad_req;
  logic [SW-1:0]    serve_cnt;

  logic [W1-1:0]    x_ext;
  logic [W1-1:0]    y_ext;
  logic [CORDW-1:0] x_mv;
  logic [CORDW-1:0] y_mv;
  dir_t             dy_mv;
  logic             miss_l_mv;
  logic             miss_r_mv;
  logic             hit_l;
  logic             hit_r;
  logic [CORDW-1:0] pad_l_next;
  logic [CORDW-1:0] pad_r_next;

  assign trigger = vsync_prev & ~vsync_cur;

  pong_ai_paddle #(
    .CORDW     (CORDW),
    .V_RES     (V_RES),
    .BALL_SIZE (BALL_SIZE),
    .PAD_H     (PAD_H),
    .AI_SPEED  (AI_SPEED)
  ) u_ai (
    .ball_y       (o_ball_y),
    .pad_y        (o_pad_r_y),
    .pad_y_next_c (pad_r_next)
  );

  // Next-frame ball position with wall reflection and goal-line detection.
  always_comb begin
    x_ext      = W1'(o_ball_x);
    y_ext      = W1'(o_ball_y);
    pad_l_next = (W1'(pad_req) > W1'(PAD_MAX)) ? CORDW'(PAD_MAX) : pad_req;
    y_mv       = o_ball_y;
    x_mv       = o_ball_x;
    dy_mv      = dy;
    miss_l_mv  = 1'b0;
    miss_r_mv  = 1'b0;
    if (dy == DIR_POS) begin
      if ((y_ext + W1'(BALL_SPEED)) >= W1'(BALL_YMX)) begin
        y_mv  = CORDW'(BALL_YMX);
        dy_mv = DIR_NEG;
      end else begin
        y_mv = CORDW'(y_ext + W1'(BALL_SPEED));
      end
    end else begin
      if (y_ext < W1'(BALL_SPEED)) begin
        y_mv  = '0;
        dy_mv = DIR_POS;
      end else begin
        y_mv = CORDW'(y_ext - W1'(BALL_SPEED));
      end
    end
    if (dx == DIR_NEG) begin
      if (x_ext < W1'(BALL_SPEED)) begin
        x_mv      = '0;
        miss_l_mv = 1'b1;
      end else begin
        x_mv = CORDW'(x_ext - W1'(BALL_SPEED));
      end
    end else begin
      if ((x_ext + W1'(BALL_SPEED)) > W1'(BALL_XMX)) begin
        x_mv      = CORDW'(BALL_XMX);
        miss_r_mv = 1'b1;
      end else begin
        x_mv = CORDW'(x_ext + W1'(BALL_SPEED));
      end
    end
  end

  // Paddle contact tests on the already-moved ball.
  always_comb begin
    hit_l = (dx == DIR_NEG)
          && (x_ext <= W1'(PAD_X_L + PAD_W))
          && ((x_ext + W1'(BALL_SIZE)) > W1'(PAD_X_L))
          && ((y_ext + W1'(BALL_SIZE)) > W1'(o_pad_l_y))
          && (y_ext < (W1'(o_pad_l_y) + W1'(PAD_H)));
    hit_r = (dx == DIR_POS)
          && ((x_ext + W1'(BALL_SIZE)) >= W1'(PAD_X_R))
          && (x_ext < W1'(PAD_X_R + PAD_W))
          && ((y_ext + W1'(BALL_SIZE)) > W1'(o_pad_r_y))
          && (y_ext < (W1'(o_pad_r_y) + W1'(PAD_H)));
  end

  always_ff @(posedge i_clk or negedge n_btn_rst) begin
    if (!n_btn_rst) begin
      state         <= IDLE;
      vsync_cur     <= 1'b1;
      vsync_prev    <= 1'b1;
      dx            <= DIR_POS;
      dy            <= DIR_POS;
      miss_l        <= 1'b0;
      miss_r        <= 1'b0;
      pad_req       <= CORDW'(PAD_Y0);
      serve_cnt     <= SW'(SERVE_FRAMES);
      o_ball_x      <= CORDW'(BALL_X0);
      o_ball_y      <= CORDW'(BALL_Y0);
      o_pad_l_y     <= CORDW'(PAD_Y0);
      o_pad_r_y     <= CORDW'(PAD_Y0);
      o_score_l     <= '0;
      o_score_r     <= '0;
      o_update_done <= 1'b0;
    end else begin
      vsync_cur     <= n_vsync;
      vsync_prev    <= vsync_cur;
      o_update_done <= 1'b0;
      if (i_pad_valid) begin
        pad_req <= i_pad_y;
      end
      case (state)
        IDLE: begin
          if (trigger) begin
            state <= PADDLES;
          end
        end
        PADDLES: begin
          o_pad_l_y <= pad_l_next;
          o_pad_r_y <= pad_r_next;
          state     <= (serve_cnt != '0) ? SERVE_WAIT : MOVE;
        end
        SERVE_WAIT: begin
          serve_cnt     <= serve_cnt - SW'(1);
          o_update_done <= 1'b1;
          state         <= IDLE;
        end
        MOVE: begin
          o_ball_x <= x_mv;
          o_ball_y <= y_mv;
          dy       <= dy_mv;
          miss_l   <= miss_l_mv;
          miss_r   <= miss_r_mv;
          state    <= BOUNCE;
        end
        BOUNCE: begin
          if (miss_l) begin
            o_score_r <= score_inc(o_score_r);
            o_ball_x  <= CORDW'(BALL_X0);
            o_ball_y  <= CORDW'(BALL_Y0);
            dx        <= DIR_NEG;
            serve_cnt <= SW'(SERVE_FRAMES);
          end else if (miss_r) begin
            o_score_l <= score_inc(o_score_l);
            o_ball_x  <= CORDW'(BALL_X0);
            o_ball_y  <= CORDW'(BALL_Y0);
            dx        <= DIR_POS;
            serve_cnt <= SW'(SERVE_FRAMES);
          end else if (hit_l) begin
            o_ball_x <= CORDW'(PAD_X_L + PAD_W);
            dx       <= DIR_POS;
          end else if (hit_r) begin
            o_ball_x <= CORDW'(PAD_X_R - BALL_SIZE);
            dx       <= DIR_NEG;
          end
          miss_l        <= 1'b0;
          miss_r        <= 1'b0;
          o_update_done <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pong_ball_engine.sv
// Self-checking bench for pong_ball_engine: a frame model feeds a scoreboard checked on each done pulse.
module tb_pong_ball_engine;

  localparam int unsigned CW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          n_vsync;
  logic          pad_valid;
  logic [CW-1:0] pad_y;
  logic [CW-1:0] ball_x, ball_y, pad_l_y, pad_r_y;
  logic [3:0]    score_l, score_r;
  logic          update_done;

  always #5 clk = ~clk;

  pong_ball_engine dut (
    .i_clk         (clk),
    .n_btn_rst     (rst_n),
    .n_vsync       (n_vsync),
    .i_pad_valid   (pad_valid),
    .i_pad_y       (pad_y),
    .o_ball_x      (ball_x),
    .o_ball_y      (ball_y),
    .o_pad_l_y     (pad_l_y),
    .o_pad_r_y     (pad_r_y),
    .o_score_l     (score_l),
    .o_score_r     (score_r),
    .o_update_done (update_done)
  );

  typedef struct {
    int bx; int by; int pl; int pr; int sl; int sr; int lat; int start;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_done = 0;

  int m_bx, m_by, m_dx, m_dy, m_pl, m_pr, m_sl, m_sr, m_serve, m_preq, m_misses;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard monitor: every done pulse must match the oldest predicted frame.
  initial forever begin : monitor
    exp_t e;
    @(posedge clk);
    #1;
    if (update_done === 1'b1) begin
      n_done++;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_done cyc=%0d got=1 exp=0", cyc);
      end else begin
        e = sb.pop_front();
        if (cyc - e.start != e.lat) begin
          bad++;
          $display("FAIL sb_latency got=%0d exp=%0d", cyc - e.start, e.lat);
        end
        total++;
        if (ball_x !== CW'(e.bx) || ball_y !== CW'(e.by)) begin
          bad++;
          $display("FAIL sb_ball got=(%0d,%0d) exp=(%0d,%0d)", ball_x, ball_y, e.bx, e.by);
        end
        total++;
        if (pad_l_y !== CW'(e.pl) || pad_r_y !== CW'(e.pr)) begin
          bad++;
          $display("FAIL sb_paddles got=(%0d,%0d) exp=(%0d,%0d)", pad_l_y, pad_r_y, e.pl, e.pr);
        end
        total++;
        if (score_l !== 4'(e.sl) || score_r !== 4'(e.sr)) begin
          bad++;
          $display("FAIL sb_scores got=(%0d,%0d) exp=(%0d,%0d)", score_l, score_r, e.sl, e.sr);
        end
      end
    end
  end

  task automatic model_reset();
    m_bx = 316; m_by = 236; m_dx = 1; m_dy = 1;
    m_pl = 216; m_pr = 216; m_sl = 0; m_sr = 0;
    m_serve = 60; m_preq = 216;
  endtask

  // Game rules evaluated with plain integers, one call per frame.
  task automatic model_frame(output int lat);
    int bc, pc, ml, mr;
    m_pl = (m_preq > 432) ? 432 : m_preq;
    bc = m_by + 4;
    pc = m_pr + 24;
    if (bc - pc >= 2) m_pr = (m_pr + 2 > 432) ? 432 : m_pr + 2;
    else if (pc - bc >= 2) m_pr = (m_pr < 2) ? 0 : m_pr - 2;
    if (m_serve != 0) begin
      m_serve--;
      lat = 4;
    end else begin
      lat = 5;
      ml = 0;
      mr = 0;
      if (m_dy == 1) begin
        if (m_by + 2 >= 472) begin m_by = 472; m_dy = 0; end
        else m_by = m_by + 2;
      end else begin
        if (m_by < 2) begin m_by = 0; m_dy = 1; end
        else m_by = m_by - 2;
      end
      if (m_dx == 0) begin
        if (m_bx < 2) begin m_bx = 0; ml = 1; end
        else m_bx = m_bx - 2;
      end else begin
        if (m_bx + 2 > 632) begin m_bx = 632; mr = 1; end
        else m_bx = m_bx + 2;
      end
      if (ml == 1) begin
        m_sr = (m_sr == 15) ? 15 : m_sr + 1;
        m_bx = 316; m_by = 236; m_dx = 0; m_serve = 60; m_misses++;
      end else if (mr == 1) begin
        m_sl = (m_sl == 15) ? 15 : m_sl + 1;
        m_bx = 316; m_by = 236; m_dx = 1; m_serve = 60;
      end else if (m_dx == 0 && m_bx <= 24 && m_bx + 8 > 16 && m_by + 8 > m_pl && m_by < m_pl + 48) begin
        m_bx = 24; m_dx = 1;
      end else if (m_dx == 1 && m_bx + 8 >= 616 && m_bx < 624 && m_by + 8 > m_pr && m_by < m_pr + 48) begin
        m_bx = 608; m_dx = 0;
      end
    end
  endtask

  // One vsync: predict, push, then wait (bounded) for the done pulse.
  task automatic do_frame();
    exp_t e;
    int lat, cnt;
    bit got;
    model_frame(lat);
    e = '{m_bx, m_by, m_pl, m_pr, m_sl, m_sr, lat, cyc};
    sb.push_back(e);
    n_vsync = 1'b0;
    got = 0;
    cnt = 0;
    while (!got && cnt < 20) begin
      @(posedge clk);
      #1;
      cnt++;
      if (cnt == 2) n_vsync = 1'b1;
      if (update_done === 1'b1) got = 1;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL frame_timeout got=no_done exp=done_within_20");
      if (sb.size() > 0) e = sb.pop_front();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic set_pad(input int y);
    pad_valid = 1'b1;
    pad_y = CW'(y);
    @(posedge clk);
    #1;
    pad_valid = 1'b0;
    m_preq = y;
  endtask

  task automatic dodge();
    set_pad((m_by < 240) ? 432 : 0);
  endtask

  task automatic test_reset();
    int d0;
    total++;
    if (ball_x !== 10'd316 || ball_y !== 10'd236) begin
      bad++; $display("FAIL reset_ball got=(%0d,%0d) exp=(316,236)", ball_x, ball_y);
    end
    total++;
    if (pad_l_y !== 10'd216 || pad_r_y !== 10'd216) begin
      bad++; $display("FAIL reset_paddles got=(%0d,%0d) exp=(216,216)", pad_l_y, pad_r_y);
    end
    total++;
    if (score_l !== 4'd0 || score_r !== 4'd0 || update_done !== 1'b0) begin
      bad++; $display("FAIL reset_scores got=(%0d,%0d,%0b) exp=(0,0,0)", score_l, score_r, update_done);
    end
    d0 = n_done;
    for (int i = 0; i < 60; i++) do_frame();
    total++;
    if (n_done - d0 != 60) begin
      bad++; $display("FAIL serve_pulses got=%0d exp=60", n_done - d0);
    end
    total++;
    if (ball_x !== 10'd316 || ball_y !== 10'd236) begin
      bad++; $display("FAIL serve_frozen got=(%0d,%0d) exp=(316,236)", ball_x, ball_y);
    end
  endtask

  task automatic test_wall_bounce();
    for (int i = 0; i < 117; i++) do_frame();
    total++;
    if (ball_y !== 10'd470 || ball_x !== 10'd550) begin
      bad++; $display("FAIL wall_pre got=(%0d,%0d) exp=(550,470)", ball_x, ball_y);
    end
    do_frame();
    total++;
    if (ball_y !== 10'd472) begin
      bad++; $display("FAIL wall_hit got=%0d exp=472", ball_y);
    end
    do_frame();
    total++;
    if (ball_y !== 10'd470) begin
      bad++; $display("FAIL wall_after got=%0d exp=470", ball_y);
    end
  endtask

  task automatic test_right_return();
    for (int i = 0; i < 27; i++) do_frame();
    total++;
    if (ball_x !== 10'd608) begin
      bad++; $display("FAIL rpad_hit_x got=%0d exp=608", ball_x);
    end
    do_frame();
    total++;
    if (ball_x !== 10'd606) begin
      bad++; $display("FAIL rpad_return_x got=%0d exp=606", ball_x);
    end
    total++;
    if (score_l !== 4'd0 || score_r !== 4'd0) begin
      bad++; $display("FAIL rpad_scores got=(%0d,%0d) exp=(0,0)", score_l, score_r);
    end
  endtask

  task automatic test_pad_clamp();
    set_pad(100);
    set_pad(470);
    do_frame();
    total++;
    if (pad_l_y !== 10'd432) begin
      bad++; $display("FAIL pad_clamp_hi got=%0d exp=432", pad_l_y);
    end
    set_pad(5);
    do_frame();
    total++;
    if (pad_l_y !== 10'd5) begin
      bad++; $display("FAIL pad_low got=%0d exp=5", pad_l_y);
    end
  endtask

  task automatic test_miss();
    int frames;
    bit first_seen;
    frames = 0;
    first_seen = 0;
    m_misses = 0;
    while (m_misses < 16 && frames < 6000) begin
      dodge();
      do_frame();
      frames++;
      if (m_misses == 1 && !first_seen) begin
        first_seen = 1;
        total++;
        if (score_r !== 4'd1 || ball_x !== 10'd316 || ball_y !== 10'd236) begin
          bad++; $display("FAIL miss_first got=(%0d,%0d,%0d) exp=(1,316,236)", score_r, ball_x, ball_y);
        end
        for (int i = 0; i < 60; i++) begin
          dodge();
          do_frame();
          frames++;
          total++;
          if (ball_x !== 10'd316 || ball_y !== 10'd236) begin
            bad++; $display("FAIL miss_freeze got=(%0d,%0d) exp=(316,236)", ball_x, ball_y);
          end
        end
        dodge();
        do_frame();
        frames++;
        total++;
        if (ball_x !== 10'd314) begin
          bad++; $display("FAIL miss_serve_left got=%0d exp=314", ball_x);
        end
      end
    end
    total++;
    if (m_misses != 16) begin
      bad++; $display("FAIL miss_budget got=%0d exp=16", m_misses);
    end
    total++;
    if (score_r !== 4'd15 || score_l !== 4'd0) begin
      bad++; $display("FAIL miss_saturate got=(%0d,%0d) exp=(0,15)", score_l, score_r);
    end
  endtask

  task automatic test_reset_mid_update();
    bit seen;
    for (int i = 0; i < 70 && m_serve != 0; i++) begin
      dodge();
      do_frame();
    end
    n_vsync = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk);
      #1;
      if (c == 2) n_vsync = 1'b1;
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (ball_x !== 10'd316 || ball_y !== 10'd236 || pad_l_y !== 10'd216 || pad_r_y !== 10'd216) begin
      bad++; $display("FAIL midrst_values got=(%0d,%0d,%0d,%0d) exp=(316,236,216,216)",
                      ball_x, ball_y, pad_l_y, pad_r_y);
    end
    total++;
    if (score_l !== 4'd0 || score_r !== 4'd0 || update_done !== 1'b0) begin
      bad++; $display("FAIL midrst_scores got=(%0d,%0d,%0b) exp=(0,0,0)", score_l, score_r, update_done);
    end
    seen = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (update_done !== 1'b0) seen = 1;
    end
    total++;
    if (seen) begin
      bad++; $display("FAIL midrst_no_done got=1 exp=0");
    end
    rst_n = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_frame();
    total++;
    if (ball_x !== 10'd316 || ball_y !== 10'd236 || score_r !== 4'd0) begin
      bad++; $display("FAIL midrst_serve got=(%0d,%0d,%0d) exp=(316,236,0)", ball_x, ball_y, score_r);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    n_vsync = 1'b1;
    pad_valid = 1'b0;
    pad_y = '0;
    model_reset();
    m_misses = 0;
    #23;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_wall_bounce();
    test_right_return();
    test_pad_clamp();
    test_miss();
    test_reset_mid_update();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL sb_leftover got=%0d exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
